// File: rtl/axis_py_lockin_pkg.sv
// axis_py_lockin_pkg: shared widths, SC packing offsets, N2 limits and the
// quarter-wave table / interpolation helpers for the lock-in reference DDS.
package axis_py_lockin_pkg;

   localparam int unsigned DDS_PHASE_W   = 44;
   localparam int unsigned DDS_SC_W      = 25;
   localparam int unsigned DDS_Q_W       = 24;
   localparam int unsigned DDS_LUT_ADDR2 = 10;

   localparam int unsigned SC_TDATA_W = 64;
   localparam int unsigned SC_LANE_W  = 32;
   localparam int unsigned SC_COS_OFS = 0;
   localparam int unsigned SC_SIN_OFS = 32;

   localparam int unsigned N2_W         = 16;
   localparam int unsigned N2_CLAMP_MIN = 2;
   localparam int unsigned N2_CLAMP_MAX = DDS_PHASE_W;

   localparam int unsigned FRAC8_W = 8;
   localparam int unsigned IPROD_W = DDS_Q_W + FRAC8_W + 3;

   localparam real PI_R = 3.14159265358979323846;

   // Entry k of the quarter-wave table: round(FS * sin(k*pi/2^(addr2+1)))
   function automatic logic [DDS_Q_W-1:0] qsin_entry(input int unsigned k,
                                                     input int unsigned addr2);
      real fs;
      real ang;
      fs  = real'((longint'(1) << DDS_Q_W) - 1);
      ang = real'(k) * PI_R / real'(longint'(1) << (addr2 + 1));
      return DDS_Q_W'($rtoi(fs * $sin(ang) + 0.5));
   endfunction

   // Linear interpolation between two table entries, rounded and clamped to [0, FS]
   function automatic logic [DDS_Q_W-1:0] interp_mag(input logic [DDS_Q_W-1:0] base,
                                                     input logic [DDS_Q_W-1:0] nb,
                                                     input logic [FRAC8_W-1:0] f8);
      logic signed [DDS_Q_W+1:0] diff;
      logic signed [IPROD_W-1:0] prod;
      logic signed [IPROD_W-1:0] sum;
      diff = $signed({2'b00, nb}) - $signed({2'b00, base});
      prod = IPROD_W'(diff) * IPROD_W'($signed({1'b0, f8}));
      sum  = IPROD_W'($signed({1'b0, base})) + ((prod + IPROD_W'(128)) >>> FRAC8_W);
      if (sum < 0)
         return '0;
      else if (sum > $signed(IPROD_W'({DDS_Q_W{1'b1}})))
         return '1;
      else
         return sum[DDS_Q_W-1:0];
   endfunction

endpackage

// File: rtl/py_quarter_sine_rom.sv
// py_quarter_sine_rom: dual-port registered quarter-wave sine ROM,
// 2^ADDR2+1 entries, contents generated by the package table function.
module py_quarter_sine_rom
   import axis_py_lockin_pkg::*;
#(
   parameter int unsigned ADDR2 = DDS_LUT_ADDR2
) (
   input  logic               i_clk,
   input  logic [ADDR2:0]     i_addr_a,
   input  logic [ADDR2:0]     i_addr_b,
   output logic [DDS_Q_W-1:0] o_data_a,
   output logic [DDS_Q_W-1:0] o_data_b
);

   localparam int unsigned DEPTH = (1 << ADDR2) + 1;

   logic [DDS_Q_W-1:0] w_lut [DEPTH];

   for (genvar k = 0; k < DEPTH; k++) begin : g_lut
      assign w_lut[k] = qsin_entry(k, ADDR2);
   end

   // Registered read on both ports
   always_ff @(posedge i_clk) begin
      o_data_a <= w_lut[i_addr_a];
      o_data_b <= w_lut[i_addr_b];
   end

endmodule

// File: rtl/axis_py_lockin_dds.sv
// axis_py_lockin_dds: power-of-2 sin/cos reference for the lock-in correlator.
// N2 changes take effect only at a phase wrap so every period is whole.
// Optional feature macro: DDS_INTERP_EN (linear interpolation, +1 latency).
module axis_py_lockin_dds
   import axis_py_lockin_pkg::*;
#(
   parameter int unsigned DPHASE_WIDTH  = DDS_PHASE_W,
   parameter int unsigned SC_DATA_WIDTH = DDS_SC_W,
   parameter int unsigned SC_Q_WIDTH    = DDS_Q_W,
   parameter int unsigned LUT_ADDR2     = DDS_LUT_ADDR2,
   parameter int unsigned N2_MIN        = N2_CLAMP_MIN,
   parameter int unsigned N2_INIT       = 10
) (
   input  logic                  a_clk,
   input  logic                  a_rst,
   input  logic [N2_W-1:0]       S_AXIS_N2_tdata,
   input  logic                  S_AXIS_N2_tvalid,
   output logic [SC_TDATA_W-1:0] M_AXIS_SC_tdata,
   output logic                  M_AXIS_SC_tvalid,
   output logic [N2_W-1:0]       M_AXIS_DDS_N2_tdata,
   output logic                  M_AXIS_DDS_N2_tvalid,
   output logic                  period_start
);

   localparam int unsigned AW = LUT_ADDR2;
   localparam int unsigned IW = LUT_ADDR2 + 1;
   localparam int unsigned FW = DPHASE_WIDTH - 2 - LUT_ADDR2;
   localparam int unsigned QW = SC_Q_WIDTH;
   localparam int unsigned SW = SC_DATA_WIDTH;

   // Quarter-wave folding: mirrored quadrants read the table backwards
   function automatic logic [IW-1:0] fold_idx(input logic mirror, input logic [AW-1:0] a);
      return mirror ? (IW'(1 << AW) - IW'(a)) : IW'(a);
   endfunction

   // S0: phase accumulator and N2 bookkeeping
   logic [DPHASE_WIDTH-1:0] r_phase;
   logic [DPHASE_WIDTH-1:0] w_inc;
   logic [DPHASE_WIDTH-1:0] w_phase_nxt;
   logic                    w_wrap;
   logic [N2_W-1:0]         r_n2_act;
   logic [N2_W-1:0]         r_n2_pend;
   logic [N2_W-1:0]         w_n2_req;
   logic [N2_W-1:0]         w_shamt;

   // Increment, wrap detect and request clamp
   always_comb begin
      w_shamt     = N2_W'(DPHASE_WIDTH) - r_n2_act;
      w_inc       = DPHASE_WIDTH'(1) << w_shamt;
      w_phase_nxt = r_phase + w_inc;
      w_wrap      = (w_phase_nxt == '0);
      w_n2_req    = S_AXIS_N2_tdata;
      if (S_AXIS_N2_tdata < N2_W'(N2_MIN))
         w_n2_req = N2_W'(N2_MIN);
      else if (S_AXIS_N2_tdata > N2_W'(DPHASE_WIDTH))
         w_n2_req = N2_W'(DPHASE_WIDTH);
   end

   // Phase advance; pending N2 is promoted only when the phase wraps
   always_ff @(posedge a_clk or posedge a_rst) begin
      if (a_rst) begin
         r_phase   <= '0;
         r_n2_act  <= N2_W'(N2_INIT);
         r_n2_pend <= N2_W'(N2_INIT);
      end else begin
         r_phase <= w_phase_nxt;
         if (S_AXIS_N2_tvalid)
            r_n2_pend <= w_n2_req;
         if (w_wrap)
            r_n2_act <= r_n2_pend;
      end
   end

   // S0 decode: quadrant, table address and folded indices
   logic [1:0]    w_q;
   logic [1:0]    w_qc;
   logic [AW-1:0] w_a;
   logic [IW-1:0] w_sidx;
   logic [IW-1:0] w_cidx;
   logic          w_unused;

   always_comb begin
      w_q    = r_phase[DPHASE_WIDTH-1 -: 2];
      w_a    = r_phase[DPHASE_WIDTH-3 -: AW];
      w_qc   = w_q + 2'd1;
      w_sidx = fold_idx(w_q[0], w_a);
      w_cidx = fold_idx(w_qc[0], w_a);
   end

   // S1 registers
   logic            r_s1_vld;
   logic            r_s1_ps;
   logic [N2_W-1:0] r_s1_n2;
   logic [IW-1:0]   r_s1_sidx;
   logic [IW-1:0]   r_s1_cidx;
   logic            r_s1_sneg;
   logic            r_s1_cneg;

   // Register the decoded indices alongside N2 and the period marker
   always_ff @(posedge a_clk or posedge a_rst) begin
      if (a_rst) begin
         r_s1_vld  <= 1'b0;
         r_s1_ps   <= 1'b0;
         r_s1_n2   <= '0;
         r_s1_sidx <= '0;
         r_s1_cidx <= '0;
         r_s1_sneg <= 1'b0;
         r_s1_cneg <= 1'b0;
      end else begin
         r_s1_vld  <= 1'b1;
         r_s1_ps   <= (r_phase == '0);
         r_s1_n2   <= r_n2_act;
         r_s1_sidx <= w_sidx;
         r_s1_cidx <= w_cidx;
         r_s1_sneg <= w_q[1];
         r_s1_cneg <= w_qc[1];
      end
   end

   // S2: ROM read (registered inside the ROM) plus side-band registers
   logic [QW-1:0]   w_s2_smag;
   logic [QW-1:0]   w_s2_cmag;
   logic            r_s2_vld;
   logic            r_s2_ps;
   logic [N2_W-1:0] r_s2_n2;
   logic            r_s2_sneg;
   logic            r_s2_cneg;

   py_quarter_sine_rom #(.ADDR2(LUT_ADDR2)) u_rom_base (
      .i_clk    (a_clk),
      .i_addr_a (r_s1_sidx),
      .i_addr_b (r_s1_cidx),
      .o_data_a (w_s2_smag),
      .o_data_b (w_s2_cmag)
   );

   // Side-band travels with the ROM read
   always_ff @(posedge a_clk or posedge a_rst) begin
      if (a_rst) begin
         r_s2_vld  <= 1'b0;
         r_s2_ps   <= 1'b0;
         r_s2_n2   <= '0;
         r_s2_sneg <= 1'b0;
         r_s2_cneg <= 1'b0;
      end else begin
         r_s2_vld  <= r_s1_vld;
         r_s2_ps   <= r_s1_ps;
         r_s2_n2   <= r_s1_n2;
         r_s2_sneg <= r_s1_sneg;
         r_s2_cneg <= r_s1_cneg;
      end
   end

   // Signals feeding the sign/pack stage
   logic            w_o_vld;
   logic            w_o_ps;
   logic [N2_W-1:0] w_o_n2;
   logic            w_o_sneg;
   logic            w_o_cneg;
   logic [QW-1:0]   w_o_smag;
   logic [QW-1:0]   w_o_cmag;

`ifdef DDS_INTERP_EN
   logic [FRAC8_W-1:0] w_f8;
   logic [IW-1:0]      w_snb;
   logic [IW-1:0]      w_cnb;
   logic [IW-1:0]      r_s1_snb;
   logic [IW-1:0]      r_s1_cnb;
   logic [FRAC8_W-1:0] r_s1_f8;
   logic [FRAC8_W-1:0] r_s2_f8;
   logic [QW-1:0]      w_s2_snbm;
   logic [QW-1:0]      w_s2_cnbm;
   logic               r_s3_vld;
   logic               r_s3_ps;
   logic [N2_W-1:0]    r_s3_n2;
   logic               r_s3_sneg;
   logic               r_s3_cneg;
   logic [QW-1:0]      r_s3_smag;
   logic [QW-1:0]      r_s3_cmag;

   // Neighbour index: forward for unmirrored quadrants, backward for mirrored
   always_comb begin
      w_f8  = r_phase[DPHASE_WIDTH-3-AW -: FRAC8_W];
      w_snb = w_q[0]  ? (w_sidx - IW'(1)) : (w_sidx + IW'(1));
      w_cnb = w_qc[0] ? (w_cidx - IW'(1)) : (w_cidx + IW'(1));
   end

   assign w_unused = ^r_phase[FW-FRAC8_W-1:0];

   // Interpolation operands follow the base indices
   always_ff @(posedge a_clk or posedge a_rst) begin
      if (a_rst) begin
         r_s1_snb <= '0;
         r_s1_cnb <= '0;
         r_s1_f8  <= '0;
         r_s2_f8  <= '0;
      end else begin
         r_s1_snb <= w_snb;
         r_s1_cnb <= w_cnb;
         r_s1_f8  <= w_f8;
         r_s2_f8  <= r_s1_f8;
      end
   end

   py_quarter_sine_rom #(.ADDR2(LUT_ADDR2)) u_rom_nb (
      .i_clk    (a_clk),
      .i_addr_a (r_s1_snb),
      .i_addr_b (r_s1_cnb),
      .o_data_a (w_s2_snbm),
      .o_data_b (w_s2_cnbm)
   );

   // S3: interpolate magnitudes
   always_ff @(posedge a_clk or posedge a_rst) begin
      if (a_rst) begin
         r_s3_vld  <= 1'b0;
         r_s3_ps   <= 1'b0;
         r_s3_n2   <= '0;
         r_s3_sneg <= 1'b0;
         r_s3_cneg <= 1'b0;
         r_s3_smag <= '0;
         r_s3_cmag <= '0;
      end else begin
         r_s3_vld  <= r_s2_vld;
         r_s3_ps   <= r_s2_ps;
         r_s3_n2   <= r_s2_n2;
         r_s3_sneg <= r_s2_sneg;
         r_s3_cneg <= r_s2_cneg;
         r_s3_smag <= interp_mag(w_s2_smag, w_s2_snbm, r_s2_f8);
         r_s3_cmag <= interp_mag(w_s2_cmag, w_s2_cnbm, r_s2_f8);
      end
   end

   // Output stage is fed from the interpolator
   always_comb begin
      w_o_vld  = r_s3_vld;
      w_o_ps   = r_s3_ps;
      w_o_n2   = r_s3_n2;
      w_o_sneg = r_s3_sneg;
      w_o_cneg = r_s3_cneg;
      w_o_smag = r_s3_smag;
      w_o_cmag = r_s3_cmag;
   end
`else
   assign w_unused = ^r_phase[FW-1:0];

   // Output stage is fed straight from the ROM (fraction truncated)
   always_comb begin
      w_o_vld  = r_s2_vld;
      w_o_ps   = r_s2_ps;
      w_o_n2   = r_s2_n2;
      w_o_sneg = r_s2_sneg;
      w_o_cneg = r_s2_cneg;
      w_o_smag = w_s2_smag;
      w_o_cmag = w_s2_cmag;
   end
`endif

   // Sign application and 64-bit packing with sign extension
   logic [SW-1:0]         w_sin;
   logic [SW-1:0]         w_cos;
   logic [SC_TDATA_W-1:0] w_sc;

   always_comb begin
      w_sin = SW'({1'b0, w_o_smag});
      w_cos = SW'({1'b0, w_o_cmag});
      if (w_o_sneg)
         w_sin = SW'(0) - w_sin;
      if (w_o_cneg)
         w_cos = SW'(0) - w_cos;
      w_sc = '0;
      w_sc[SC_COS_OFS +: SC_LANE_W] = {{(SC_LANE_W-SW){w_cos[SW-1]}}, w_cos};
      w_sc[SC_SIN_OFS +: SC_LANE_W] = {{(SC_LANE_W-SW){w_sin[SW-1]}}, w_sin};
   end

   // Output registers
   always_ff @(posedge a_clk or posedge a_rst) begin
      if (a_rst) begin
         M_AXIS_SC_tdata      <= '0;
         M_AXIS_SC_tvalid     <= 1'b0;
         M_AXIS_DDS_N2_tdata  <= '0;
         M_AXIS_DDS_N2_tvalid <= 1'b0;
         period_start         <= 1'b0;
      end else begin
         M_AXIS_SC_tdata      <= w_o_vld ? w_sc : '0;
         M_AXIS_SC_tvalid     <= w_o_vld;
         M_AXIS_DDS_N2_tdata  <= w_o_vld ? w_o_n2 : '0;
         M_AXIS_DDS_N2_tvalid <= w_o_vld;
         period_start         <= w_o_vld & w_o_ps;
      end
   end

endmodule

// File: tb/tb_axis_py_lockin_dds.sv
// tb_axis_py_lockin_dds: randomized/directed bench for axis_py_lockin_dds
// against a period-level reference model. Honors DDS_INTERP_EN.
module tb_axis_py_lockin_dds;

`ifdef DDS_INTERP_EN
   localparam int LAT    = 4;
   localparam bit INTERP = 1'b1;
`else
   localparam int LAT    = 3;
   localparam bit INTERP = 1'b0;
`endif
   localparam real PI  = 3.141592653589793;
   localparam int  FS  = 16777215;

   logic        a_clk = 1'b0;
   logic        a_rst = 1'b1;
   logic [15:0] n2_td = '0;
   logic        n2_tv = 1'b0;
   logic [63:0] sc_tdata;
   logic        sc_tvalid;
   logic [15:0] n2o_tdata;
   logic        n2o_tvalid;
   logic        ps;

   axis_py_lockin_dds dut (
      .a_clk                (a_clk),
      .a_rst                (a_rst),
      .S_AXIS_N2_tdata      (n2_td),
      .S_AXIS_N2_tvalid     (n2_tv),
      .M_AXIS_SC_tdata      (sc_tdata),
      .M_AXIS_SC_tvalid     (sc_tvalid),
      .M_AXIS_DDS_N2_tdata  (n2o_tdata),
      .M_AXIS_DDS_N2_tvalid (n2o_tvalid),
      .period_start         (ps)
   );

   always #5 a_clk = ~a_clk;

   int n_checks = 0;
   int n_fail   = 0;
   int T [0:1024];

   typedef struct {
      bit        vld;
      bit [43:0] ph;
      int        n2;
   } smp_t;

   smp_t   pipe_q[$];
   longint j_m;        // sample index within the current period
   int     n2_act_m;
   int     n2_pend_m;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int clamp_n2(input int r);
      if (r < 2)  return 2;
      if (r > 44) return 44;
      return r;
   endfunction

   function automatic bit [43:0] ph_of(input longint j, input int n2);
      return 44'(j) << (44 - n2);
   endfunction

   // Reference sine of a 44-bit phase: quarter-wave fold plus optional interpolation
   function automatic logic [24:0] fold(input bit [43:0] ph);
      int q, a, f8, i;
      longint v, nb;
      q  = int'(ph[43:42]);
      a  = int'(ph[41:32]);
      f8 = int'(ph[31:24]);
      i  = (q % 2 == 1) ? 1024 - a : a;
      v  = T[i];
      if (INTERP) begin
         nb = (q % 2 == 1) ? T[i-1] : T[i+1];
         v  = v + (((nb - v) * f8 + 128) >>> 8);
         if (v < 0)  v = 0;
         if (v > FS) v = FS;
      end
      if (q >= 2) v = -v;
      return 25'(v);
   endfunction

   function automatic logic [63:0] exp_sc(input bit [43:0] ph);
      logic [24:0] s, c;
      s = fold(ph);
      c = fold(ph + 44'h400_0000_0000);
      return {{7{s[24]}}, s, {7{c[24]}}, c};
   endfunction

   // Push the model's current S0 sample and compare the one due at the output now
   task automatic compare_cycle();
      smp_t e;
      pipe_q.push_back('{1'b1, ph_of(j_m, n2_act_m), n2_act_m});
      e = pipe_q.pop_front();
      check("sc_tvalid", 64'(sc_tvalid), 64'(e.vld));
      check("n2_tvalid", 64'(n2o_tvalid), 64'(e.vld));
      if (e.vld) begin
         check("sc_tdata", sc_tdata, exp_sc(e.ph));
         check("n2_tdata", 64'(n2o_tdata), 64'(e.n2));
         check("period_start", 64'(ps), 64'(e.ph == 44'd0));
      end
   endtask

   task automatic model_reset();
      j_m       = 0;
      n2_act_m  = 10;
      n2_pend_m = 10;
      pipe_q.delete();
      repeat (LAT) pipe_q.push_back('{1'b0, 44'd0, 0});
   endtask

   // One clock: drive request, advance model at period granularity, check outputs
   task automatic step(input bit tv, input int td);
      n2_tv = tv;
      n2_td = 16'(td);
      if (j_m + 1 == (longint'(1) << n2_act_m)) begin
         j_m      = 0;
         n2_act_m = n2_pend_m;
      end else begin
         j_m++;
      end
      if (tv) n2_pend_m = clamp_n2(td);
      @(posedge a_clk);
      @(negedge a_clk);
      n2_tv = 1'b0;
      compare_cycle();
   endtask

   task automatic run(input int n);
      repeat (n) step(1'b0, 0);
   endtask

   task automatic run_to_j(input longint target);
      int guard;
      guard = 0;
      while (j_m != target && guard < 5000) begin
         step(1'b0, 0);
         guard++;
      end
      check("run_to_j_timeout", 64'(j_m), 64'(target));
   endtask

   task automatic run_to_wrap();
      run_to_j((longint'(1) << n2_act_m) - 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_sc_tvalid"}, 64'(sc_tvalid), 64'd0);
      check({tag, "_n2_tvalid"}, 64'(n2o_tvalid), 64'd0);
      check({tag, "_sc_tdata"}, sc_tdata, 64'd0);
      check({tag, "_n2_tdata"}, 64'(n2o_tdata), 64'd0);
      check({tag, "_period_start"}, 64'(ps), 64'd0);
   endtask

   // Assert reset at a negedge, check outputs clear immediately, release later
   task automatic do_reset(input int cycles);
      a_rst = 1'b1;
      n2_tv = 1'b0;
      #1;
      check_reset_outputs("rst_now");
      repeat (cycles) @(negedge a_clk);
      check_reset_outputs("rst_hold");
      a_rst = 1'b0;
      model_reset();
      compare_cycle();
   endtask

   initial begin
      for (int k = 0; k <= 1024; k++)
         T[k] = $rtoi(real'(FS) * $sin(real'(k) * PI / 2048.0) + 0.5);

      // Power-on reset, N2 = 10
      a_rst = 1'b1;
      repeat (3) @(negedge a_clk);
      check_reset_outputs("por");
      a_rst = 1'b0;
      model_reset();
      compare_cycle();
      run(1100);

      // Mid-period change to N2 = 4 at sample 300
      run_to_j(300);
      step(1'b1, 4);
      run(1200);

      // Clamp low: 1 -> 2
      step(1'b1, 1);
      run(60);

      // Last request wins
      step(1'b1, 6);
      step(1'b1, 8);
      run(100);

      // Request in the wrap cycle is applied one period later
      run_to_wrap();
      step(1'b1, 3);
      run(600);

      // Random requests at random times
      for (int r = 0; r < 8; r++) begin
         step(1'b1, int'($urandom_range(0, 12)));
         run(int'($urandom_range(10, 300)));
      end

      // Fine resolution, N2 = 20
      step(1'b1, 20);
      run(5000);

      // Reset mid-operation at sample 700 with a request pending
      do_reset(2);
      run(300);
      step(1'b1, int'($urandom_range(3, 9)));
      run(399);
      do_reset(3);
      run(1100);

      // Clamp high: 60 -> 44
      step(1'b1, 60);
      run(1200);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
